// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
package fifo_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam logic [DEF_FIFO_WIDTH-1:0] DEF_PAD_VALUE = 16'h0000;
    localparam int unsigned BEAT_CNT_W = 16;
    localparam int unsigned PAD_CNT_W  = 8;

    typedef enum logic [1:0] {EMPTY, HALF, FULL} pack_state_e;

    typedef logic [2*DEF_FIFO_WIDTH-1:0] beat_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed output stream; master is the packer side.
interface fifo_rd_packer_if #(
    parameter int unsigned FIFO_WIDTH = fifo_pkg::DEF_FIFO_WIDTH
);
    logic [FIFO_WIDTH-1:0]   fifo_data_out;
    logic                    fifo_empty;
    logic                    fifo_underflow;
    logic                    fifo_rd_en;
    logic [2*FIFO_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_partial;

    modport master (
        input  fifo_data_out, fifo_empty, fifo_underflow, out_ready,
        output fifo_rd_en, out_data, out_valid, out_partial
    );

    modport slave (
        output fifo_data_out, fifo_empty, fifo_underflow, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_partial
    );
endinterface

// File: rtl/fifo_rd_packer_stats.sv
// Accepted-beat and padded-beat counters; exists only when PACKER_STATS_EN is defined.
`ifdef PACKER_STATS_EN
module fifo_rd_packer_stats
    import fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beat_accept,
    input  logic                  pad_accept,
    output logic [BEAT_CNT_W-1:0] beat_count,
    output logic [PAD_CNT_W-1:0]  pad_count
);
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [PAD_CNT_W-1:0]  pad_q, pad_d;

    always_comb begin
        beat_d = beat_q;
        pad_d  = pad_q;
        if (beat_accept) begin
            beat_d = beat_q + BEAT_CNT_W'(1);
        end
        // Pad count saturates rather than wrapping.
        if (pad_accept && (pad_q != {PAD_CNT_W{1'b1}})) begin
            pad_d = pad_q + PAD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            pad_q  <= '0;
        end else begin
            beat_q <= beat_d;
            pad_q  <= pad_d;
        end
    end

    assign beat_count = beat_q;
    assign pad_count  = pad_q;
endmodule
`endif

// File: rtl/fifo_rd_packer.sv
// Packs pairs of FIFO words into 32-bit beats, with flush-to-partial and sticky underflow.
// Optional PACKER_STATS_EN adds beat_count/pad_count outputs.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter logic [FIFO_WIDTH-1:0] PAD_VALUE = DEF_PAD_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  err_underflow,
`ifdef PACKER_STATS_EN
    output logic [BEAT_CNT_W-1:0] beat_count,
    output logic [PAD_CNT_W-1:0]  pad_count,
`endif
    fifo_rd_packer_if.master      bus
);
    localparam int unsigned W = FIFO_WIDTH;

    pack_state_e    state_q, state_d;
    logic [1:0]     held_q, held_d;
    logic           pending_q, pending_d;
    logic           flush_req_q, flush_req_d;
    logic           err_q, err_d;
    logic           valid_q, valid_d;
    logic           partial_q, partial_d;
    logic [2*W-1:0] data_q, data_d;
    logic           rd_en, accept, flush_any;

    assign accept    = valid_q & bus.out_ready;
    assign flush_any = flush_req_q | flush;
    assign rd_en     = !rst && !bus.fifo_empty && !flush_req_q && (state_q != FULL) &&
                       (({1'b0, held_q} + {2'b00, pending_q}) < 3'd2);

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        pending_d   = rd_en;
        flush_req_d = flush_any;
        err_d       = err_q;
        valid_d     = valid_q;
        partial_d   = partial_q;
        data_d      = data_q;

        if (accept) begin
            held_d    = 2'd0;
            valid_d   = 1'b0;
            partial_d = 1'b0;
        end

        if (pending_q) begin
            if (bus.fifo_underflow) begin
                err_d = 1'b1;
            end else if (held_q == 2'd0) begin
                data_d[W-1:0] = bus.fifo_data_out;
                held_d        = 2'd1;
            end else begin
                data_d[2*W-1:W] = bus.fifo_data_out;
                held_d          = 2'd2;
                valid_d         = 1'b1;
            end
        end

        // Flush sees the post-landing count and waits until no read is in flight.
        if (flush_any && !pending_d && !valid_d) begin
            if (held_d == 2'd0) begin
                flush_req_d = 1'b0;
            end else if (held_d == 2'd1) begin
                data_d[2*W-1:W] = PAD_VALUE;
                valid_d         = 1'b1;
                partial_d       = 1'b1;
            end
        end

        if (valid_d) begin
            state_d = FULL;
        end else if (held_d == 2'd1) begin
            state_d = HALF;
        end else begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            held_q      <= 2'd0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            partial_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            pending_q   <= pending_d;
            flush_req_q <= flush_req_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            partial_q   <= partial_d;
            data_q      <= data_d;
        end
    end

    assign bus.fifo_rd_en  = rd_en;
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_partial = partial_q;
    assign err_underflow   = err_q;

`ifdef PACKER_STATS_EN
    fifo_rd_packer_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .beat_accept(accept),
        .pad_accept (accept & partial_q),
        .beat_count (beat_count),
        .pad_count  (pad_count)
    );
`endif
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: vector table, hand sequences, randomized run against a word-queue model.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic err_underflow;
`ifdef PACKER_STATS_EN
    logic [15:0] beat_count;
    logic [7:0]  pad_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_packer_if bus ();

    fifo_rd_packer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .err_underflow(err_underflow),
`ifdef PACKER_STATS_EN
        .beat_count   (beat_count),
        .pad_count    (pad_count),
`endif
        .bus          (bus)
    );

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          nw;
        int          fcyc;
        int          stall;
        logic [31:0] exp_data;
        bit          exp_part;
        int          exp_rd;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] fq[$];
    logic [15:0] good_q[$];
    logic [15:0] land_word = 16'h0;
    bit          rd_prev = 0;
    bit          rst_v = 1, flush_v = 0, ready_v = 0, under_arm = 0, under_seen = 0;
    int          under_pct = 0;
    int          beats_model = 0, pads_model = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, sample after settle, update the model for the next edge.
    task automatic tick();
        bit    landing;
        bit    uf;
        beat_t exp;
        @(negedge clk);
        landing = rd_prev;
        uf = 1'b0;
        if (landing && under_arm) begin
            uf = 1'b1;
            under_arm = 1'b0;
        end else if (under_pct > 0 && $urandom_range(99) < 32'(under_pct)) begin
            uf = 1'b1;
        end
        bus.fifo_data_out  = landing ? land_word : 16'($urandom);
        bus.fifo_underflow = uf;
        bus.fifo_empty     = (fq.size() == 0);
        bus.out_ready      = ready_v;
        flush              = flush_v;
        rst                = rst_v;
        #1;
        check("err_sticky", 32'(err_underflow), 32'(under_seen));
        if (prev_hold) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", bus.out_data, prev_data);
        end
        prev_hold = bus.out_valid && !ready_v && !rst_v;
        prev_data = bus.out_data;
        if (bus.fifo_rd_en) check("rd_rule", 32'({bus.fifo_empty, bus.out_valid, rst}), 32'd0);
        if (rst_v) begin
            good_q.delete();
            beats_model = 0;
            pads_model  = 0;
            under_seen  = 1'b0;
        end else begin
            if (bus.out_valid && ready_v) begin
                if (bus.out_partial) begin
                    check("partial_words", 32'(good_q.size()), 32'd1);
                    exp = (good_q.size() >= 1) ? {DEF_PAD_VALUE, good_q.pop_front()} : '0;
                    pads_model++;
                end else begin
                    check("full_words", 32'(good_q.size()), 32'd2);
                    exp = '0;
                    if (good_q.size() >= 2) begin
                        exp[15:0]  = good_q.pop_front();
                        exp[31:16] = good_q.pop_front();
                    end
                end
                check("beat_data", bus.out_data, exp);
                beats_model++;
            end
            if (landing) begin
                if (uf) under_seen = 1'b1;
                else good_q.push_back(land_word);
            end
        end
        rd_prev = bus.fifo_rd_en && !rst_v;
        if (rd_prev) land_word = (fq.size() > 0) ? fq.pop_front() : 16'hDEAD;
    endtask

    task automatic do_reset();
        fq.delete();
        rst_v = 1; flush_v = 0; ready_v = 0; under_pct = 0; under_arm = 0;
        tick();
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst_v = 0;
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_partial", 32'(bus.out_partial), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
    endtask

    task automatic wait_valid(input string name, output bit got);
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            if (bus.out_valid) got = 1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        bit   got;
        int   rd_cnt;
        bit   saw_rd;

        bus.fifo_data_out = '0; bus.fifo_empty = 1'b1; bus.fifo_underflow = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'h1111, 16'h2222, 2, -1, 0, 32'h2222_1111, 1'b0, 2};
        vecs[1] = '{16'hAAAA, 16'hBBBB, 2, -1, 5, 32'hBBBB_AAAA, 1'b0, 2};
        vecs[2] = '{16'h00C3, 16'h0000, 1,  4, 0, 32'h0000_00C3, 1'b1, 1};
        vecs[3] = '{16'h1234, 16'hABCD, 2,  2, 2, 32'hABCD_1234, 1'b0, 2};
        vecs[4] = '{16'hFFFF, 16'h0000, 1,  0, 3, 32'h0000_FFFF, 1'b1, 1};
        vecs[5] = '{16'h5A5A, 16'hC3C3, 2,  1, 0, 32'hC3C3_5A5A, 1'b0, 2};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 2,  0, 1, 32'h0000_0F0F, 1'b1, 1};

        foreach (vecs[i]) begin
            do_reset();
            fq.push_back(vecs[i].w0);
            if (vecs[i].nw == 2) fq.push_back(vecs[i].w1);
            rd_cnt = 0;
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                flush_v = (c == vecs[i].fcyc);
                tick();
                if (bus.fifo_rd_en) rd_cnt++;
                if (bus.out_valid) got = 1;
            end
            flush_v = 0;
            check("vec_valid", 32'(got), 32'd1);
            check("vec_data", bus.out_data, vecs[i].exp_data);
            check("vec_partial", 32'(bus.out_partial), 32'(vecs[i].exp_part));
            for (int s = 0; s < vecs[i].stall; s++) begin
                tick();
                if (bus.fifo_rd_en) rd_cnt++;
            end
            check("vec_rd_count", 32'(rd_cnt), 32'(vecs[i].exp_rd));
            ready_v = 1;
            tick();
            ready_v = 0;
            tick();
            check("vec_valid_drop", 32'(bus.out_valid), 32'd0);
            // A fresh read proves any flush request was released by the accept.
            if (fq.size() == 0) fq.push_back(16'h7E7E);
            saw_rd = bus.fifo_rd_en;
            for (int c = 0; c < 4 && !saw_rd; c++) begin
                tick();
                saw_rd = bus.fifo_rd_en;
            end
            check("vec_reads_resume", 32'(saw_rd), 32'd1);
        end

        // Underflow on the first landing: that word is dropped, the next two still pack.
        do_reset();
        fq.push_back(16'h5555); fq.push_back(16'h6666); fq.push_back(16'h7777);
        under_arm = 1;
        wait_valid("uf_valid", got);
        check("uf_data", bus.out_data, 32'h7777_6666);
        check("uf_partial", 32'(bus.out_partial), 32'd0);
        check("uf_err", 32'(err_underflow), 32'd1);
        ready_v = 1; tick(); ready_v = 0; tick();
        check("uf_err_sticky", 32'(err_underflow), 32'd1);

        // Reset with one word held and one read in flight.
        do_reset();
        fq.push_back(16'hA001); fq.push_back(16'hA002);
        fq.push_back(16'hB001); fq.push_back(16'hB002);
        tick(); tick();
        rst_v = 1;
        tick();
        check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        rst_v = 0;
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_partial", 32'(bus.out_partial), 32'd0);
        wait_valid("mid_rst_beat", got);
        check("mid_rst_beat_data", bus.out_data, 32'hB002_B001);
        ready_v = 1; tick(); ready_v = 0; tick();

        // Randomized traffic against the word-queue model.
        do_reset();
        under_pct = 10;
        for (int n = 0; n < 3000; n++) begin
            if (fq.size() < 8 && $urandom_range(99) < 40) fq.push_back(16'($urandom));
            ready_v = ($urandom_range(99) < 70);
            flush_v = ($urandom_range(99) < 5);
            rst_v   = ($urandom_range(199) == 0);
            tick();
        end
        rst_v = 0; under_pct = 0; ready_v = 1;
        for (int n = 0; n < 300; n++) begin
            flush_v = (n % 10 == 0);
            tick();
        end
        flush_v = 0;
        tick(); tick();
        check("drain_fifo_empty", 32'(fq.size()), 32'd0);
        check("drain_model_empty", 32'(good_q.size()), 32'd0);
        check("drain_valid", 32'(bus.out_valid), 32'd0);

`ifdef PACKER_STATS_EN
        check("beat_count", 32'(beat_count), 32'(beats_model & 16'hFFFF));
        check("pad_count", 32'(pad_count), 32'((pads_model > 255) ? 255 : pads_model));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end
endmodule
